// File: rtl/iris_pkg.sv
// Shared constants for the Iris MLP input path.
// N_FEAT features of FEAT_W bits each form one flat VEC_W-bit classifier vector;
// the classifier imports VEC_W from here so both sides agree on the width.
package iris_pkg;

    localparam int N_FEAT = 4;
    localparam int FEAT_W = 4;
    localparam int VEC_W  = N_FEAT * FEAT_W;
    localparam int IDX_W  = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } pack_state_t;

endpackage

// File: rtl/iris_feat_quant.sv
// Combinational quantizer for one raw sensor sample.
// Removes OFFSET, shifts right by SHIFT and clamps to FEAT_W bits unsigned.
// Ports:
//   raw  - unsigned raw sample (RAW_W bits)
//   q    - quantized feature (FEAT_W bits)
//   sat  - high when the shifted value exceeded the FEAT_W-bit maximum
module iris_feat_quant #(
    parameter int RAW_W  = 10,
    parameter int FEAT_W = 4,
    parameter int SHIFT  = 5,
    parameter int OFFSET = 0
) (
    input  logic [RAW_W-1:0]  raw,
    output logic [FEAT_W-1:0] q,
    output logic              sat
);

    localparam logic [RAW_W:0]   OFF   = (RAW_W+1)'(OFFSET);
    localparam logic [RAW_W-1:0] Q_MAX = RAW_W'((1 << FEAT_W) - 1);

    logic [RAW_W:0]   diff;
    logic [RAW_W-1:0] shifted;

    // One extra bit so the top bit of diff is the sign of (raw - OFFSET).
    assign diff    = {1'b0, raw} - OFF;
    assign shifted = diff[RAW_W-1:0] >> SHIFT;

    always_comb begin
        q   = '0;
        sat = 1'b0;
        if (!diff[RAW_W]) begin
            if (shifted > Q_MAX) begin
                q   = '1;
                sat = 1'b1;
            end else begin
                q = shifted[FEAT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/iris_feature_packer.sv
// Packs quantized sensor samples into the classifier's flat input vector.
// Samples arrive one feature per beat on a valid/ready stream, framed by s_last;
// the packed vector is held behind valid/ready until the classifier takes it.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   s_valid/s_ready   - raw sample handshake; s_data raw sample, s_last end of frame
//   m_valid/m_ready   - packed vector handshake; m_data feature k at [k*FEAT_W +: FEAT_W]
//   frame_err         - one-cycle pulse when a frame is too short or too long
//   sat_flag          - some feature of the held vector saturated high
//
// state   | meaning
// --------+-----------------------------------------------------------
// COLLECT | accepting samples into the shadow vector (or resyncing)
// HOLD    | packed vector presented on m_data, waiting for m_ready
module iris_feature_packer
    import iris_pkg::*;
#(
    parameter int RAW_W  = 10,
    parameter int SHIFT  = 5,
    parameter int OFFSET = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [RAW_W-1:0] s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [VEC_W-1:0] m_data,
    output logic             frame_err,
    output logic             sat_flag
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_FEAT - 1);

    pack_state_t       state;
    logic [IDX_W-1:0]  idx;
    logic [VEC_W-1:0]  shadow;
    logic [VEC_W-1:0]  shadow_next;
    logic              sat_acc;
    logic              resync;
    logic [FEAT_W-1:0] q;
    logic              q_sat;
    logic              s_fire;

    iris_feat_quant #(
        .RAW_W  (RAW_W),
        .FEAT_W (FEAT_W),
        .SHIFT  (SHIFT),
        .OFFSET (OFFSET)
    ) u_quant (
        .raw (s_data),
        .q   (q),
        .sat (q_sat)
    );

    assign s_fire = s_valid && s_ready;

    // Shadow vector with the current sample dropped into slot idx; used both
    // for the slot write and for the final-beat copy into m_data.
    always_comb begin
        shadow_next = shadow;
        for (int k = 0; k < N_FEAT; k++) begin
            if (idx == IDX_W'(k)) begin
                shadow_next[k*FEAT_W +: FEAT_W] = q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= COLLECT;
            idx       <= '0;
            shadow    <= '0;
            sat_acc   <= 1'b0;
            resync    <= 1'b0;
            s_ready   <= 1'b1;
            m_valid   <= 1'b0;
            m_data    <= '0;
            frame_err <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                COLLECT: begin
                    if (s_fire) begin
                        if (resync) begin
                            // Drop beats up to and including the next s_last.
                            if (s_last) begin
                                resync <= 1'b0;
                            end
                        end else if (idx == IDX_LAST) begin
                            idx     <= '0;
                            shadow  <= '0;
                            sat_acc <= 1'b0;
                            if (s_last) begin
                                m_data   <= shadow_next;
                                sat_flag <= sat_acc | q_sat;
                                m_valid  <= 1'b1;
                                s_ready  <= 1'b0;
                                state    <= HOLD;
                            end else begin
                                frame_err <= 1'b1;
                                resync    <= 1'b1;
                            end
                        end else if (s_last) begin
                            frame_err <= 1'b1;
                            idx       <= '0;
                            shadow    <= '0;
                            sat_acc   <= 1'b0;
                        end else begin
                            shadow  <= shadow_next;
                            sat_acc <= sat_acc | q_sat;
                            idx     <= idx + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        m_valid  <= 1'b0;
                        s_ready  <= 1'b1;
                        sat_flag <= 1'b0;
                        state    <= COLLECT;
                    end
                end
                default: begin
                    state   <= COLLECT;
                    m_valid <= 1'b0;
                    s_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iris_feature_packer.sv
module tb_iris_feature_packer;

    typedef struct packed {
        logic [15:0] data;
        logic        sat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [9:0]  s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        frame_err;
    logic        sat_flag;

    int   vecs = 0;
    int   errs = 0;
    int   cyc = 0;
    int   ferr_cnt = 0;
    int   mv_cnt = 0;
    int   pops = 0;
    int   acc_cyc = 0;
    exp_t exp_q[$];

    iris_feature_packer #(
        .RAW_W  (10),
        .SHIFT  (5),
        .OFFSET (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .frame_err (frame_err),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: sampled mid-cycle; a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (frame_err === 1'b1) ferr_cnt++;
            if (m_valid === 1'b1) mv_cnt++;
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                vecs++;
                assert (exp_q.size() != 0)
                else begin
                    errs++;
                    $error("FAIL unexpected_m_valid: observed m_data %h with no frame expected", m_data);
                end
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    pops++;
                    vecs++;
                    assert (m_data === e.data)
                    else begin
                        errs++;
                        $error("FAIL m_data: observed %h expected %h", m_data, e.data);
                    end
                    vecs++;
                    assert (sat_flag === e.sat)
                    else begin
                        errs++;
                        $error("FAIL sat_flag: observed %b expected %b (m_data %h)", sat_flag, e.sat, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one beat; returns 1 time unit after the accepting edge.
    task automatic send(input logic [9:0] d, input logic last);
        int n;
        n       = 0;
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        @(negedge clk);
        while (s_ready !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        vecs++;
        assert (s_ready === 1'b1)
        else begin
            errs++;
            $error("FAIL send_timeout: observed s_ready %b expected 1 for data %0d", s_ready, d);
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        int mv_base;
        int fe_base;
        int mr_cyc;

        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        tick(2);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_sat_flag", 32'(sat_flag), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        rst_n = 1'b1;
        tick(1);

        // Nominal frame: features 2,4,10,15.
        mv_base = mv_cnt;
        exp_q.push_back('{data: 16'hFA42, sat: 1'b0});
        send(10'd64, 1'b0);
        send(10'd128, 1'b0);
        send(10'd320, 1'b0);
        send(10'd480, 1'b1);
        check("latency_m_valid", 32'(m_valid), 32'd1);
        check("latency_s_ready", 32'(s_ready), 32'd0);
        tick(3);
        check("nominal_valid_cycles", 32'(mv_cnt - mv_base), 32'd1);

        // Saturating frame then a clean one.
        exp_q.push_back('{data: 16'h2F22, sat: 1'b1});
        send(10'd64, 1'b0);
        send(10'd64, 1'b0);
        send(10'd1023, 1'b0);
        send(10'd64, 1'b1);
        exp_q.push_back('{data: 16'hC963, sat: 1'b0});
        send(10'd100, 1'b0);
        send(10'd200, 1'b0);
        send(10'd300, 1'b0);
        send(10'd400, 1'b1);
        tick(2);

        // Backpressure: classifier stalls 5 cycles.
        m_ready = 1'b0;
        exp_q.push_back('{data: 16'hE531, sat: 1'b0});
        send(10'd32, 1'b0);
        send(10'd96, 1'b0);
        send(10'd160, 1'b0);
        send(10'd479, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_m_valid", 32'(m_valid), 32'd1);
            check("bp_m_data", 32'(m_data), 32'hE531);
            check("bp_s_ready", 32'(s_ready), 32'd0);
            tick(1);
        end
        m_ready = 1'b1;
        mr_cyc  = cyc;
        exp_q.push_back('{data: 16'h1000, sat: 1'b0});
        send(10'd10, 1'b0);
        check("bp_first_accept_cycle", 32'(acc_cyc - mr_cyc), 32'd2);
        send(10'd20, 1'b0);
        send(10'd30, 1'b0);
        send(10'd40, 1'b1);
        tick(2);

        // Short frame.
        fe_base = ferr_cnt;
        mv_base = mv_cnt;
        send(10'd64, 1'b0);
        send(10'd64, 1'b1);
        check("short_frame_err_now", 32'(frame_err), 32'd1);
        tick(1);
        check("short_frame_err_gone", 32'(frame_err), 32'd0);
        tick(2);
        check("short_err_pulses", 32'(ferr_cnt - fe_base), 32'd1);
        check("short_no_m_valid", 32'(mv_cnt - mv_base), 32'd0);
        exp_q.push_back('{data: 16'h2222, sat: 1'b0});
        for (int i = 0; i < 4; i++) send(10'd64, i == 3);
        tick(2);

        // Long frame: s_last only on 6th beat.
        fe_base = ferr_cnt;
        mv_base = mv_cnt;
        for (int i = 0; i < 6; i++) send(10'd320, i == 5);
        tick(2);
        check("long_err_pulses", 32'(ferr_cnt - fe_base), 32'd1);
        check("long_no_m_valid", 32'(mv_cnt - mv_base), 32'd0);
        exp_q.push_back('{data: 16'h24AF, sat: 1'b0});
        send(10'd480, 1'b0);
        send(10'd320, 1'b0);
        send(10'd128, 1'b0);
        send(10'd64, 1'b1);
        tick(2);

        // Reset while holding an unconsumed vector.
        m_ready = 1'b0;
        send(10'd1023, 1'b0);
        send(10'd64, 1'b0);
        send(10'd64, 1'b0);
        send(10'd64, 1'b1);
        tick(1);
        check("hold_before_reset", 32'(m_valid), 32'd1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("hold_rst_m_valid", 32'(m_valid), 32'd0);
        check("hold_rst_m_data", 32'(m_data), 32'h0);
        check("hold_rst_sat_flag", 32'(sat_flag), 32'd0);
        check("hold_rst_s_ready", 32'(s_ready), 32'd1);
        m_ready = 1'b1;
        tick(1);

        // Reset mid-frame after two saturating samples.
        send(10'd1023, 1'b0);
        send(10'd1023, 1'b0);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("mid_rst_m_valid", 32'(m_valid), 32'd0);
        exp_q.push_back('{data: 16'hFA42, sat: 1'b0});
        send(10'd64, 1'b0);
        send(10'd128, 1'b0);
        send(10'd320, 1'b0);
        send(10'd480, 1'b1);
        tick(5);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("frames_received", 32'(pops), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
